// File: rtl/collision_detector.sv
// collision_detector
//   Once per frame, on a single-cycle start, takes a snapshot of the ship,
//   asteroid and shot records. It then checks the ship against each asteroid
//   (one asteroid per cycle) and each shot against each asteroid (one pair per
//   cycle, shot-major). Each shot hit is offered through hit_valid/hit_ack.
//   Record layout: [33] active, [25:16] y, [15:6] x, [5:0] direction.
// Ports
//   clk, reset_n       clock, async active-low reset
//   start              scan request, sampled only in IDLE
//   ship/asteroids/shots  entity records, index 0 in the LSBs
//   busy, done         scan in progress / one-cycle completion pulse
//   ship_hit           ship overlapped an active asteroid in the last scan
//   hit_valid/hit_shot/hit_ast/hit_ack  shot-hit handshake
//   score              accumulated, saturating score (COLLISION_SCORE_EN only)
// Build option: define COLLISION_SCORE_EN to add the score port and counter.
module collision_detector #(
  parameter int ENTITY_SIZE   = 34,
  parameter int MAX_ASTEROIDS = 3,
  parameter int MAX_SHOTS     = 3,
  parameter int AST_SIZE      = 16,
  parameter int SHIP_SIZE     = 8,
  parameter int SCORE_PER_HIT = 10,
  localparam int SW = (MAX_SHOTS > 1) ? $clog2(MAX_SHOTS) : 1,
  localparam int AW = (MAX_ASTEROIDS > 1) ? $clog2(MAX_ASTEROIDS) : 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               start,
  input  logic [ENTITY_SIZE-1:0]             ship,
  input  logic [MAX_ASTEROIDS*ENTITY_SIZE-1:0] asteroids,
  input  logic [MAX_SHOTS*ENTITY_SIZE-1:0]   shots,
  output logic                               busy,
  output logic                               done,
  output logic                               ship_hit,
  output logic                               hit_valid,
  output logic [SW-1:0]                      hit_shot,
  output logic [AW-1:0]                      hit_ast,
  input  logic                               hit_ack
`ifdef COLLISION_SCORE_EN
  ,output logic [15:0]                       score
`endif
);

  localparam int ACT = ENTITY_SIZE - 1;
  localparam logic [10:0] AST_L  = 11'(AST_SIZE);
  localparam logic [10:0] SHIP_L = 11'(SHIP_SIZE);
  localparam logic [AW-1:0] A_LAST = AW'(MAX_ASTEROIDS - 1);
  localparam logic [SW-1:0] S_LAST = SW'(MAX_SHOTS - 1);

  typedef enum logic [2:0] {IDLE, SHIP_CHK, PAIR_CHK, REPORT, DONE} state_t;
  state_t state;

  // Unpacked input fields
  logic [MAX_ASTEROIDS-1:0]       in_ast_act;
  logic [MAX_ASTEROIDS-1:0][9:0]  in_ast_x, in_ast_y;
  logic [MAX_SHOTS-1:0]           in_shot_act;
  logic [MAX_SHOTS-1:0][9:0]      in_shot_x, in_shot_y;
  logic [MAX_ASTEROIDS-1:0]       unused_ast;
  logic [MAX_SHOTS-1:0]           unused_shot;
  logic                           unused_ship;

  for (genvar i = 0; i < MAX_ASTEROIDS; i++) begin : g_ast
    assign in_ast_act[i] = asteroids[i*ENTITY_SIZE + ACT];
    assign in_ast_x[i]   = asteroids[i*ENTITY_SIZE + 6  +: 10];
    assign in_ast_y[i]   = asteroids[i*ENTITY_SIZE + 16 +: 10];
    assign unused_ast[i] = ^{asteroids[i*ENTITY_SIZE + 26 +: 7], asteroids[i*ENTITY_SIZE +: 6]};
  end
  for (genvar i = 0; i < MAX_SHOTS; i++) begin : g_shot
    assign in_shot_act[i] = shots[i*ENTITY_SIZE + ACT];
    assign in_shot_x[i]   = shots[i*ENTITY_SIZE + 6  +: 10];
    assign in_shot_y[i]   = shots[i*ENTITY_SIZE + 16 +: 10];
    assign unused_shot[i] = ^{shots[i*ENTITY_SIZE + 26 +: 7], shots[i*ENTITY_SIZE +: 6]};
  end
  assign unused_ship = ^{ship[32:26], ship[5:0]};

  // Snapshot
  logic                          ship_act;
  logic [9:0]                    ship_x, ship_y;
  logic [MAX_ASTEROIDS-1:0]      ast_act;
  logic [MAX_ASTEROIDS-1:0][9:0] ast_x, ast_y;
  logic [MAX_SHOTS-1:0]          shot_act;
  logic [MAX_SHOTS-1:0][9:0]     shot_x, shot_y;

  logic [SW-1:0] s_idx;
  logic [AW-1:0] a_idx;

  // Current operands widened to 11 bits so box edges near 1023 never wrap
  logic [10:0] ax, ay, px, py, sx, sy;
  logic        ship_ovl, pair_hit;

  assign ax = {1'b0, ast_x[a_idx]};
  assign ay = {1'b0, ast_y[a_idx]};
  assign px = {1'b0, shot_x[s_idx]};
  assign py = {1'b0, shot_y[s_idx]};
  assign sx = {1'b0, ship_x};
  assign sy = {1'b0, ship_y};

  assign ship_ovl = ship_act && ast_act[a_idx] &&
                    (sx < ax + AST_L) && (ax < sx + SHIP_L) &&
                    (sy < ay + AST_L) && (ay < sy + SHIP_L);
  assign pair_hit = shot_act[s_idx] && ast_act[a_idx] &&
                    (ax <= px) && (px < ax + AST_L) &&
                    (ay <= py) && (py < ay + AST_L);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ship_hit  <= 1'b0;
      hit_valid <= 1'b0;
      hit_shot  <= '0;
      hit_ast   <= '0;
      s_idx     <= '0;
      a_idx     <= '0;
      ship_act  <= 1'b0;
      ship_x    <= '0;
      ship_y    <= '0;
      ast_act   <= '0;
      ast_x     <= '0;
      ast_y     <= '0;
      shot_act  <= '0;
      shot_x    <= '0;
      shot_y    <= '0;
`ifdef COLLISION_SCORE_EN
      score     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          ship_act <= ship[ACT];
          ship_x   <= ship[15:6];
          ship_y   <= ship[25:16];
          ast_act  <= in_ast_act;
          ast_x    <= in_ast_x;
          ast_y    <= in_ast_y;
          shot_act <= in_shot_act;
          shot_x   <= in_shot_x;
          shot_y   <= in_shot_y;
          ship_hit <= 1'b0;
          busy     <= 1'b1;
          s_idx    <= '0;
          a_idx    <= '0;
          state    <= SHIP_CHK;
        end
        SHIP_CHK: begin
          if (ship_ovl) ship_hit <= 1'b1;
          if (a_idx == A_LAST) begin
            a_idx <= '0;
            state <= PAIR_CHK;
          end else begin
            a_idx <= a_idx + 1'b1;
          end
        end
        PAIR_CHK: begin
          if (pair_hit) begin
            hit_valid <= 1'b1;
            hit_shot  <= s_idx;
            hit_ast   <= a_idx;
            state     <= REPORT;
          end else if (a_idx == A_LAST) begin
            a_idx <= '0;
            if (s_idx == S_LAST) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              s_idx <= s_idx + 1'b1;
            end
          end else begin
            a_idx <= a_idx + 1'b1;
          end
        end
        REPORT: if (hit_ack) begin
          hit_valid       <= 1'b0;
          // Retire both entities in the snapshot so neither is counted twice
          shot_act[s_idx] <= 1'b0;
          ast_act[a_idx]  <= 1'b0;
`ifdef COLLISION_SCORE_EN
          if (score > 16'hFFFF - 16'(SCORE_PER_HIT)) score <= 16'hFFFF;
          else                                       score <= score + 16'(SCORE_PER_HIT);
`endif
          // The consumed shot's remaining pairs are skipped
          a_idx <= '0;
          if (s_idx == S_LAST) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            s_idx <= s_idx + 1'b1;
            state <= PAIR_CHK;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_detector.sv
module tb_collision_detector;

  logic         clk, reset_n, start, hit_ack;
  logic [33:0]  ship;
  logic [101:0] asteroids, shots;
  logic         busy, done, ship_hit, hit_valid;
  logic [1:0]   hit_shot, hit_ast;
`ifdef COLLISION_SCORE_EN
  logic [15:0]  score;
`endif

  collision_detector dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ship(ship),
    .asteroids(asteroids), .shots(shots), .busy(busy), .done(done),
    .ship_hit(ship_hit), .hit_valid(hit_valid), .hit_shot(hit_shot),
    .hit_ast(hit_ast), .hit_ack(hit_ack)
`ifdef COLLISION_SCORE_EN
    , .score(score)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;

  // Stimulus records held by the bench
  logic [33:0] r_ship, r_ast[3], r_shot[3];

  // Expected results
  int exp_s[$], exp_a[$];
  int exp_edges, exp_score = 0;
  bit exp_ship;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] mk(input bit act, input int x, input int y);
    logic [9:0] xx, yy;
    xx = x[9:0];
    yy = y[9:0];
    return {act, 7'd0, yy, xx, 6'($urandom_range(63))};
  endfunction

  function automatic int fx(input logic [33:0] r); return int'(r[15:6]);  endfunction
  function automatic int fy(input logic [33:0] r); return int'(r[25:16]); endfunction

  // Reference: plain-integer boxes, hits consumed in shot-major order,
  // latency = ship pass + pairs actually visited + (1 + ack wait) per report
  task automatic model(input int ack_d);
    bit alive[3];
    int visited = 0, hits = 0;
    exp_s.delete();
    exp_a.delete();
    exp_ship = 0;
    for (int a = 0; a < 3; a++) begin
      alive[a] = r_ast[a][33];
      if (r_ship[33] && alive[a] &&
          fx(r_ship) < fx(r_ast[a]) + 16 && fx(r_ast[a]) < fx(r_ship) + 8 &&
          fy(r_ship) < fy(r_ast[a]) + 16 && fy(r_ast[a]) < fy(r_ship) + 8)
        exp_ship = 1;
    end
    for (int s = 0; s < 3; s++)
      for (int a = 0; a < 3; a++) begin
        visited++;
        if (r_shot[s][33] && alive[a] &&
            fx(r_ast[a]) <= fx(r_shot[s]) && fx(r_shot[s]) < fx(r_ast[a]) + 16 &&
            fy(r_ast[a]) <= fy(r_shot[s]) && fy(r_shot[s]) < fy(r_ast[a]) + 16) begin
          exp_s.push_back(s);
          exp_a.push_back(a);
          alive[a] = 0;
          hits++;
          break;
        end
      end
    exp_edges = 3 + visited + hits * (ack_d + 1);
  endtask

  task automatic drive_records();
    ship = r_ship;
    for (int i = 0; i < 3; i++) begin
      asteroids[i*34 +: 34] = r_ast[i];
      shots[i*34 +: 34]     = r_shot[i];
    end
  endtask

  task automatic scramble_inputs();
    logic [63:0] rr;
    rr = {$urandom, $urandom};
    ship = rr[33:0];
    for (int i = 0; i < 3; i++) begin
      rr = {$urandom, $urandom};
      asteroids[i*34 +: 34] = rr[33:0];
      rr = {$urandom, $urandom};
      shots[i*34 +: 34] = rr[33:0];
    end
  endtask

  task automatic run_scan(input int ack_d, input bit restart);
    int edges, es, ea, pulses;
    model(ack_d);
    drive_records();
    start = 1'b1;
    tick();
    start = 1'b0;
    scramble_inputs();
    chk("busy_after_start", busy, 1);
    chk("ship_hit_cleared", ship_hit, 0);
    edges = 0;
    while (done !== 1'b1 && edges < 400) begin
      if (hit_valid === 1'b1) begin
        if (exp_s.size() > 0) begin
          es = exp_s.pop_front();
          ea = exp_a.pop_front();
        end else begin
          es = -1;
          ea = -1;
        end
        chk("hit_shot", 32'(hit_shot), es);
        chk("hit_ast", 32'(hit_ast), ea);
        for (int k = 0; k < ack_d; k++) begin
          tick();
          edges++;
          chk("hold_valid", hit_valid, 1);
          chk("hold_shot", 32'(hit_shot), es);
          chk("hold_ast", 32'(hit_ast), ea);
        end
        hit_ack = 1'b1;
        tick();
        edges++;
        hit_ack = 1'b0;
        exp_score = (exp_score + 10 > 65535) ? 65535 : exp_score + 10;
        chk("valid_after_ack", hit_valid, 0);
      end else begin
        if (restart && edges == 2) start = 1'b1;
        tick();
        edges++;
        start = 1'b0;
      end
    end
    chk("done_seen", done, 1);
    chk("latency", edges, exp_edges);
    chk("busy_at_done", busy, 0);
    chk("ship_hit", ship_hit, exp_ship);
    chk("hits_left", exp_s.size(), 0);
`ifdef COLLISION_SCORE_EN
    chk("score", score, exp_score);
`endif
    tick();
    chk("done_one_cycle", done, 0);
    if (restart) begin
      pulses = 0;
      for (int k = 0; k < 14; k++) begin
        tick();
        if (done === 1'b1) pulses++;
      end
      chk("extra_done_pulses", pulses, 0);
    end
  endtask

  task automatic clear_records();
    r_ship = mk(1, 600, 600);
    for (int i = 0; i < 3; i++) begin
      r_ast[i]  = mk(0, 0, 0);
      r_shot[i] = mk(0, 0, 0);
    end
  endtask

  initial begin
    int guard;
    reset_n = 1'b0; start = 1'b0; hit_ack = 1'b0;
    ship = '0; asteroids = '0; shots = '0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ship_hit", ship_hit, 0);
    chk("rst_hit_valid", hit_valid, 0);
    chk("rst_hit_shot", 32'(hit_shot), 0);
    chk("rst_hit_ast", 32'(hit_ast), 0);
`ifdef COLLISION_SCORE_EN
    chk("rst_score", score, 0);
`endif
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // No hits: asteroids active, shots inactive
    clear_records();
    r_ast[0] = mk(1, 10, 10); r_ast[1] = mk(1, 200, 50); r_ast[2] = mk(1, 900, 900);
    run_scan(0, 0);

    // Single hit with a 5-cycle ack wait
    clear_records();
    r_shot[1] = mk(1, 40, 40); r_ast[2] = mk(1, 32, 32);
    run_scan(5, 0);

    // Two shots inside one asteroid: only the first is reported
    clear_records();
    r_ast[0] = mk(1, 200, 200);
    r_shot[0] = mk(1, 205, 205); r_shot[1] = mk(1, 210, 210);
    run_scan(1, 0);

    // Ship overlap plus no wrap-around at the right edge
    clear_records();
    r_ship = mk(1, 100, 100);
    r_ast[0] = mk(1, 107, 92);
    r_ast[1] = mk(1, 1020, 500);
    r_shot[0] = mk(1, 2, 505);
    run_scan(0, 0);

    // Second start while busy is ignored
    clear_records();
    r_shot[2] = mk(1, 47, 47); r_ast[0] = mk(1, 32, 32);
    run_scan(2, 1);

    // Reset while a hit is pending
    clear_records();
    r_shot[1] = mk(1, 40, 40); r_ast[2] = mk(1, 32, 32);
    drive_records();
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (hit_valid !== 1'b1 && guard < 40) begin
      tick();
      guard++;
    end
    chk("abort_reached_report", hit_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_hit_valid", hit_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_hit_shot", 32'(hit_shot), 0);
    exp_score = 0;
`ifdef COLLISION_SCORE_EN
    chk("abort_score", score, 0);
`endif
    #2;
    reset_n = 1'b1;
    tick();
    chk("abort_idle_busy", busy, 0);

    // Randomized frames in a small playfield so hits are frequent
    for (int n = 0; n < 40; n++) begin
      r_ship = mk(($urandom_range(3) != 0), $urandom_range(80), $urandom_range(80));
      for (int i = 0; i < 3; i++) begin
        r_ast[i]  = mk($urandom_range(1), $urandom_range(60), $urandom_range(60));
        r_shot[i] = mk($urandom_range(1), $urandom_range(80), $urandom_range(80));
      end
      run_scan(int'($urandom_range(3)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/collision_detector.md
Name: collision_detector

Overview:
- Consumer of the per-frame entity records (ship, asteroids, shots).
- On each `start` it snapshots all records, scans ship-vs-asteroid and shot-vs-asteroid pairs, and reports hits.
- Each shot hit is reported through a valid/ack handshake that drives the shot controller's `delete_shot`/`shot_address` inputs and the asteroid kill logic.
- Ship collisions raise a flag. One scan per frame, started from the move clock tick.

Parameters:
- ENTITY_SIZE, 34, record width; bit 33 = active, [25:16] = y, [15:6] = x, [5:0] = direction.
- MAX_ASTEROIDS, 3, number of asteroid records.
- MAX_SHOTS, 3, number of shot records.
- AST_SIZE, 16, asteroid bounding box edge in pixels.
- SHIP_SIZE, 8, ship bounding box edge in pixels.
- SCORE_PER_HIT, 10, score increment (only with SCORE_EN).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle scan request
- ship  in  ENTITY_SIZE  ship record
- asteroids  in  MAX_ASTEROIDS*ENTITY_SIZE  packed records, index 0 in the LSBs
- shots  in  MAX_SHOTS*ENTITY_SIZE  packed records, index 0 in the LSBs
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse when the scan completes
- ship_hit  out  1  ship overlapped an active asteroid during the last scan
- hit_valid  out  1  shot/asteroid hit pending
- hit_shot  out  max(1,$clog2(MAX_SHOTS))  index of the hitting shot
- hit_ast  out  max(1,$clog2(MAX_ASTEROIDS))  index of the asteroid hit
- hit_ack  in  1  consumer accepted the hit
- score  out  16  accumulated score (SCORE_EN only)

Behaviour:
- Reset (async, reset_n=0): state IDLE; busy, done, ship_hit, hit_valid = 0; hit_shot, hit_ast = 0; score = 0. Reset mid-scan aborts immediately; no hit is reported.
- States: IDLE, SHIP_CHK, PAIR_CHK, REPORT, DONE.
- IDLE:
  - When start=1, latch ship, asteroids and shots into snapshot registers on the same edge.
  - Clear ship_hit, go to SHIP_CHK, busy=1.
  - start is ignored in every other state.
- SHIP_CHK:
  - One asteroid per cycle, a = 0..MAX_ASTEROIDS-1.
  - Check: both records active AND box overlap, i.e. ship.x < ast.x+AST_SIZE AND ast.x < ship.x+SHIP_SIZE, and the same for y.
  - On overlap, ship_hit is set (sticky until the next start).
  - After the last asteroid, go to PAIR_CHK.
- PAIR_CHK:
  - One pair per cycle, shot-major order: s = 0..MAX_SHOTS-1, a = 0..MAX_ASTEROIDS-1.
  - Hit condition: shot active, asteroid active (in the snapshot), and ast.x <= shot.x < ast.x+AST_SIZE, and the same for y.
  - On a hit: load hit_shot=s, hit_ast=a; set hit_valid=1; go to REPORT.
- REPORT:
  - hit_valid, hit_shot and hit_ast are held stable until hit_ack=1 is sampled.
  - On that edge: clear hit_valid; clear the snapshot active bits of shot s and asteroid a, so no double kill occurs.
  - Resume PAIR_CHK at shot s+1, asteroid 0; the remaining pairs of the consumed shot are skipped.
  - hit_ack outside REPORT is ignored.
- DONE: entered after the last pair. done=1 for exactly one cycle, busy=0, return to IDLE.
- Arithmetic:
  - Coordinates are 10-bit unsigned; sums are computed in 11 bits.
  - No wrap-around: an asteroid at x=1020 covers 1020..1035 and does not cover x=2.
- Latency with no hits: done is high in the cycle after edge E0+MAX_ASTEROIDS+MAX_SHOTS*MAX_ASTEROIDS, where E0 is the edge that samples start. For the defaults this is 12 edges after E0.
- Each report adds 1 + (ack wait) cycles and removes the skipped pairs of the consumed shot.
- Input records may change during a scan; only the snapshot is used.

Optional Feature:
- Macro: COLLISION_SCORE_EN.
- When defined:
  - The score port exists.
  - score increments by SCORE_PER_HIT on each accepted hit (the hit_ack edge in REPORT).
  - score saturates at 16'hFFFF and clears only on reset.
- When undefined: no score port and no score register; all other behaviour is identical.

Test Plan:
- No hits: all shots inactive, start pulse -> busy=1 next cycle, done pulse 12 edges after start edge, hit_valid never set, ship_hit=0.
- Single hit: shot1 at (40,40) active, ast2 at (32,32) active, start -> hit_valid=1 with hit_shot=1, hit_ast=2. Hold hit_ack=0 for 5 cycles -> outputs stable. Pulse ack -> hit_valid=0; done follows.
- Double kill prevention: shots 0 and 1 both inside ast0 -> exactly one report (shot0, ast0); shot1 is not reported because ast0 was cleared in the snapshot.
- Ship hit and edge: ship at (100,100) with ast at (107,92) -> ship_hit=1. Asteroid at x=1020, shot at x=2, same y -> no hit.
- Abort and ignore: reset_n=0 while in REPORT -> hit_valid=0, busy=0, state IDLE. A second start while busy -> ignored, only one done pulse.
- Score (COLLISION_SCORE_EN): two acked hits -> score=20; preload near saturation -> score stays 16'hFFFF.
